// File: rtl/mmio_pwm_bank_if.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pwm_bank_if
// Description : Data-memory bus port of the PWM bank (write strobe, word
//               address, write data, registered read data).
// Revision    : 1.0 - initial release
// ============================================================================
interface mmio_pwm_bank_if;
    logic        wren;
    logic [11:0] address;
    logic [31:0] data;
    logic [31:0] q;

    modport master (output wren, address, data, input q);
    modport slave  (input wren, address, data, output q);
endinterface
`default_nettype wire

// File: rtl/mmio_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : mmio_pwm_bank
// Description : Memory-mapped bank of CHANNELS PWM generators sharing one
//               prescaler and period counter; double-buffered duty registers.
//               Define PWM_IMMEDIATE_UPDATE_EN to bypass period buffering.
// Revision    : 1.0 - initial release
// ============================================================================
module mmio_pwm_bank #(
    parameter int          CHANNELS  = 4,
    parameter int          DUTY_W    = 8,
    parameter int          PRESCALE  = 25,
    parameter logic [11:0] BASE_ADDR = 12'hF00
) (
    input  wire logic              clock,
    input  wire logic              reset,
    mmio_pwm_bank_if.slave         bus,
    output logic [CHANNELS-1:0]    pwm_out,
    output logic                   tick_clk,
    output logic                   period_start
);

    localparam int                 c_PRE_W   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [c_PRE_W-1:0] c_PRE_MAX = c_PRE_W'(PRESCALE - 1);
    localparam logic [DUTY_W-1:0]  c_CNT_MAX = '1;

    logic [c_PRE_W-1:0]  r_pre;
    logic [DUTY_W-1:0]   r_cnt;
    logic                r_tick_clk;
    logic                r_period_start;
    logic [CHANNELS-1:0] r_enable;
    logic [31:0]         r_q;

    logic                w_tick;
    logic                w_wrap;
    logic [11:0]         w_off;
    logic                w_wr_mask;
    logic [CHANNELS-1:0] w_wr_duty;
    logic [DUTY_W-1:0]   w_shadow [CHANNELS];
    logic [31:0]         w_rdata;
    logic                w_unused;

    assign w_tick    = (r_pre == c_PRE_MAX);
    assign w_wrap    = w_tick && (r_cnt == c_CNT_MAX);
    // Addresses below the base wrap to large offsets and fall out of the map.
    assign w_off     = bus.address - BASE_ADDR;
    assign w_wr_mask = bus.wren && (w_off == 12'(CHANNELS));
    assign w_unused  = ^bus.data;

    assign bus.q        = r_q;
    assign tick_clk     = r_tick_clk;
    assign period_start = r_period_start;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_pre          <= '0;
            r_cnt          <= '0;
            r_tick_clk     <= 1'b0;
            r_period_start <= 1'b0;
            r_enable       <= '0;
            r_q            <= '0;
        end else begin
            if (w_tick) begin
                r_pre      <= '0;
                r_cnt      <= r_cnt + 1'b1;
                r_tick_clk <= ~r_tick_clk;
            end else begin
                r_pre      <= r_pre + 1'b1;
            end
            r_period_start <= w_wrap;
            if (w_wr_mask) begin
                r_enable <= bus.data[CHANNELS-1:0];
            end
            r_q <= w_rdata;
        end
    end

    // Readback returns the shadow (last written) duty, not the active one.
    always_comb begin
        w_rdata = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (w_off == 12'(k)) begin
                w_rdata = 32'(w_shadow[k]);
            end
        end
        if (w_off == 12'(CHANNELS)) begin
            w_rdata = 32'(r_enable);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        logic [DUTY_W-1:0] r_shadow;
        logic [DUTY_W-1:0] r_active;
        logic              r_pwm;

        assign w_wr_duty[i] = bus.wren && (w_off == 12'(i));
        assign w_shadow[i]  = r_shadow;
        assign pwm_out[i]   = r_pwm;

        always_ff @(posedge clock) begin
            if (reset) begin
                r_shadow <= '0;
                r_active <= '0;
                r_pwm    <= 1'b0;
            end else begin
                if (w_wr_duty[i]) begin
                    r_shadow <= bus.data[DUTY_W-1:0];
                end
`ifdef PWM_IMMEDIATE_UPDATE_EN
                if (w_wr_duty[i]) begin
                    r_active <= bus.data[DUTY_W-1:0];
                end
`else
                // A write landing on the wrap cycle must not be lost behind the stale shadow.
                if (w_wrap) begin
                    r_active <= w_wr_duty[i] ? bus.data[DUTY_W-1:0] : r_shadow;
                end
`endif
                r_pwm <= r_enable[i] && (r_cnt < r_active);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mmio_pwm_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_mmio_pwm_bank
// Description : Self-checking bench for mmio_pwm_bank (4 ch, 4-bit duty,
//               prescale 2) with a cycle-level reference scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mmio_pwm_bank;
    localparam int          CH   = 4;
    localparam int          DW   = 4;
    localparam int          PS   = 2;
    localparam logic [11:0] BASE = 12'hF00;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic [CH-1:0] pwm_out;
    logic          tick_clk;
    logic          period_start;

    mmio_pwm_bank_if bus ();

    mmio_pwm_bank #(
        .CHANNELS (CH),
        .DUTY_W   (DW),
        .PRESCALE (PS),
        .BASE_ADDR(BASE)
    ) u_dut (
        .clock       (clock),
        .reset       (reset),
        .bus         (bus.slave),
        .pwm_out     (pwm_out),
        .tick_clk    (tick_clk),
        .period_start(period_start)
    );

    always #5 clock = ~clock;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: next outputs computed at each edge, compared half a cycle later.
    typedef struct packed {
        logic [31:0]   q;
        logic [CH-1:0] pwm;
        logic          tclk;
        logic          ps;
    } exp_t;

    exp_t          sb [$];
    int            m_pre;
    logic [DW-1:0] m_cnt;
    logic          m_tclk;
    logic          m_ps;
    logic [31:0]   m_q;
    logic [CH-1:0] m_pwm;
    logic [CH-1:0] m_en;
    logic [DW-1:0] m_shadow [CH];
    logic [DW-1:0] m_act    [CH];

    always @(posedge clock) begin : model
        logic        tick, wrap, wr;
        logic [11:0] off;
        logic [31:0] nq;
        exp_t        e;
        if (reset) begin
            m_pre = 0; m_cnt = '0; m_tclk = 1'b0; m_ps = 1'b0;
            m_q = '0; m_pwm = '0; m_en = '0;
            for (int i = 0; i < CH; i++) begin
                m_shadow[i] = '0;
                m_act[i]    = '0;
            end
        end else begin
            tick = (m_pre == PS - 1);
            wrap = tick && (m_cnt == 4'hF);
            off  = bus.address - BASE;
            nq   = '0;
            if (off < 12'(CH))       nq = 32'(m_shadow[off]);
            else if (off == 12'(CH)) nq = 32'(m_en);
            for (int i = 0; i < CH; i++) begin
                m_pwm[i] = m_en[i] && (m_cnt < m_act[i]);
                wr = bus.wren && (off == 12'(i));
`ifdef PWM_IMMEDIATE_UPDATE_EN
                if (wr) m_act[i] = bus.data[DW-1:0];
`else
                if (wrap) m_act[i] = wr ? bus.data[DW-1:0] : m_shadow[i];
`endif
                if (wr) m_shadow[i] = bus.data[DW-1:0];
            end
            if (bus.wren && off == 12'(CH)) m_en = bus.data[CH-1:0];
            m_ps = wrap;
            m_q  = nq;
            if (tick) begin
                m_pre  = 0;
                m_cnt  = m_cnt + 1'b1;
                m_tclk = ~m_tclk;
            end else begin
                m_pre  = m_pre + 1;
            end
        end
        e.q = m_q; e.pwm = m_pwm; e.tclk = m_tclk; e.ps = m_ps;
        sb.push_back(e);
    end

    always @(negedge clock) begin : compare
        exp_t e;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sb_q",            bus.q,               e.q);
            check("sb_pwm_out",      32'(pwm_out),        32'(e.pwm));
            check("sb_tick_clk",     32'(tick_clk),       32'(e.tclk));
            check("sb_period_start", 32'(period_start),   32'(e.ps));
        end
    end

    task automatic bus_wr(input logic [11:0] a, input logic [31:0] d);
        bus.wren = 1'b1; bus.address = a; bus.data = d;
        @(negedge clock);
        bus.wren = 1'b0;
    endtask

    task automatic wait_ps(input string tag);
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < 40) begin
            @(negedge clock);
            k++;
            seen = period_start;
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic count_hi(input int n, output int c0, output int c1, output int c2, output int c3);
        c0 = 0; c1 = 0; c2 = 0; c3 = 0;
        repeat (n) begin
            @(negedge clock);
            c0 += int'(pwm_out[0]); c1 += int'(pwm_out[1]);
            c2 += int'(pwm_out[2]); c3 += int'(pwm_out[3]);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int c0, c1, c2, c3, n, pre;
        bit seen;
        bus.wren = 1'b0; bus.address = '0; bus.data = '0;

        // 1. reset, tick_clk phase, period length
        repeat (3) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        check("tclk_after_rel1", 32'(tick_clk), 32'd0);
        check("pwm_after_rel",   32'(pwm_out),  32'd0);
        @(negedge clock);
        check("tclk_after_rel2", 32'(tick_clk), 32'd1);
        wait_ps("ps_first");
        n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clock); n++; seen = period_start;
        end
        check("ps_interval", 32'(n), 32'd32);

        // 2. channel 0 at duty 4
        bus_wr(BASE + 12'd0, 32'd4);
        bus_wr(BASE + 12'd4, 32'h1);
        wait_ps("ps_t2");
        count_hi(32, c0, c1, c2, c3);
        check("t2_ch0_high", 32'(c0), 32'd8);
        check("t2_ch321_high", 32'(c1 + c2 + c3), 32'd0);

        // 3. mid-period write to channel 1
        bus_wr(BASE + 12'd4, 32'h3);
        repeat (8) @(negedge clock);
        bus_wr(BASE + 12'd1, 32'd15);
        @(negedge clock);
        check("t3_rd_duty1", bus.q, 32'd15);
        pre = 0; n = 0; seen = 1'b0;
        while (!seen && n < 40) begin
            @(negedge clock); n++;
            pre += int'(pwm_out[1]);
            seen = period_start;
        end
        check("ps_t3", 32'(seen), 32'd1);
`ifdef PWM_IMMEDIATE_UPDATE_EN
        check("t3_ch1_early", 32'(pre > 0), 32'd1);
`else
        check("t3_ch1_held", 32'(pre), 32'd0);
`endif
        count_hi(32, c0, c1, c2, c3);
        check("t3_ch1_high", 32'(c1), 32'd30);
        check("t3_ch0_high", 32'(c0), 32'd8);

        // 4. write landing exactly on the wrap cycle
        bus_wr(BASE + 12'd2, 32'd3);
        bus_wr(BASE + 12'd4, 32'h7);
        wait_ps("ps_t4");
        repeat (31) @(negedge clock);
        bus_wr(BASE + 12'd2, 32'd9);
        check("t4_wrap_aligned", 32'(period_start), 32'd1);
        count_hi(32, c0, c1, c2, c3);
        check("t4_ch2_high", 32'(c2), 32'd18);
        check("t4_ch1_high", 32'(c1), 32'd30);

        // 5. disable/re-enable channel 0 while high
        repeat (2) @(negedge clock);
        check("t5_ch0_before", 32'(pwm_out[0]), 32'd1);
        bus_wr(BASE + 12'd4, 32'h6);
        @(negedge clock);
        check("t5_ch0_off", 32'(pwm_out[0]), 32'd0);
        bus_wr(BASE + 12'd4, 32'h7);
        wait_ps("ps_t5");
        count_hi(32, c0, c1, c2, c3);
        check("t5_ch0_resume", 32'(c0), 32'd8);

        // 6. pending shadows discarded by reset; width truncation and ignored writes
        repeat (5) @(negedge clock);
        bus_wr(BASE + 12'd3, 32'hABCD_EF5A);
        @(negedge clock);
        check("t6_rd_trunc", bus.q, 32'hA);
        bus_wr(BASE + 12'd0, 32'd1);
        bus_wr(BASE + 12'd5, 32'd5);
        bus_wr(12'h000, 32'd5);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        for (int k = 0; k <= CH + 1; k++) begin
            bus.address = BASE + 12'(k);
            @(negedge clock);
            check($sformatf("t6_rd_base%0d", k), bus.q, 32'd0);
        end
        bus.address = 12'h000;
        @(negedge clock);
        check("t6_rd_000", bus.q, 32'd0);
        count_hi(64, c0, c1, c2, c3);
        check("t6_no_pulses", 32'(c0 + c1 + c2 + c3), 32'd0);

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire
